key_schedule_iter: RTL and testbench

// - Sequential AES key expansion for AES-128/192/256, selected per request; expands one 32-bit word per cycle.
// - Stores the full schedule (up to 60 words) and serves 128-bit round keys through a registered read port.
// - Sits between key load logic and the cipher round engine; replaces the fixed-width combinational expander.

---
 rtl/key_schedule_iter_pkg.sv | 76 +++++++
 rtl/key_schedule_iter_if.sv | 27 ++
 rtl/aes_sbox.sv | 11 +
 rtl/key_schedule_iter.sv | 156 +++++++++++++++
 tb/tb_key_schedule_iter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/key_schedule_iter_pkg.sv
// Shared AES key-schedule definitions: widths, key_len encodings, Nk/Nr lookups,
// round-constant helpers and the forward S-box table.
package key_schedule_iter_pkg;

   localparam int unsigned KEY_W     = 256;
   localparam int unsigned MAX_WORDS = 60;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned RK_W      = 128;
   localparam int unsigned NR_W      = 4;
   localparam int unsigned NK_W      = 4;
   localparam int unsigned WIDX_W    = 6;

   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      KL_128     = 2'd0,
      KL_192     = 2'd1,
      KL_256     = 2'd2,
      KL_ILLEGAL = 2'd3
   } key_len_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } state_e;

   function automatic logic [NK_W-1:0] nk_of(input logic [1:0] kl);
      case (kl)
         KL_192:  nk_of = 4'd6;
         KL_256:  nk_of = 4'd8;
         default: nk_of = 4'd4;
      endcase
   endfunction

   function automatic logic [NR_W-1:0] nr_of(input logic [1:0] kl);
      case (kl)
         KL_192:  nr_of = 4'd12;
         KL_256:  nr_of = 4'd14;
         default: nr_of = 4'd10;
      endcase
   endfunction

   // Index of the final schedule word, 4*(Nr+1)-1
   function automatic logic [WIDX_W-1:0] last_of(input logic [1:0] kl);
      case (kl)
         KL_192:  last_of = 6'd51;
         KL_256:  last_of = 6'd59;
         default: last_of = 6'd43;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] r);
      xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/key_schedule_iter_if.sv
// Request/status/round-key-read bundle between key load logic, the expander and the round engine.
interface key_schedule_iter_if;
   import key_schedule_iter_pkg::*;

   logic              start;
   logic [1:0]        key_len;
   logic [KEY_W-1:0]  key;
   logic              ready;
   logic              busy;
   logic              done;
   logic              err;
   logic              key_valid;
   logic [NR_W-1:0]   nr;
   logic [IDX_W-1:0]  rk_idx;
   logic [RK_W-1:0]   rk_out;

   modport master (
      output start, key_len, key, rk_idx,
      input  ready, busy, done, err, key_valid, nr, rk_out
   );

   modport slave (
      input  start, key_len, key, rk_idx,
      output ready, busy, done, err, key_valid, nr, rk_out
   );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte.
module aes_sbox
   import key_schedule_iter_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] data_o
);

   assign data_o = SBOX[in_i];

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES-128/192/256 key expander: one schedule word per cycle into a 60-word store,
// with a registered 128-bit round-key read port.
module key_schedule_iter
   import key_schedule_iter_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   key_schedule_iter_if.slave bus_if
);

   state_e              state_q, state_d;
   logic                ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                kv_q, kv_d;
   logic [NR_W-1:0]     nr_q, nr_d, run_nr_q, run_nr_d;
   logic [NK_W-1:0]     nk_q, nk_d;
   logic [2:0]          imod_q, imod_d;
   logic [WIDX_W-1:0]   i_q, i_d, last_q, last_d;
   logic [7:0]          rcon_q, rcon_d;
   logic [RK_W-1:0]     rk_q, rk_d;
   logic [WORD_W-1:0]   w_q [MAX_WORDS];

   logic                accept, wr_word;
   logic [WORD_W-1:0]   prev_w, back_w, sub_in, sub_out, t_w, new_w;
   logic [IDX_W-1:0]    rk_sel;
   logic [WIDX_W-1:0]   rk_base;

   // Next-word datapath: i%Nk==0 -> SubWord(RotWord) ^ rcon; AES-256 i%8==4 -> SubWord only
   assign prev_w = w_q[i_q - 6'd1];
   assign back_w = w_q[i_q - WIDX_W'(nk_q)];
   assign sub_in = (imod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (.in_i(sub_in[8*b +: 8]), .data_o(sub_out[8*b +: 8]));
   end

   always_comb begin
      t_w = prev_w;
      if (imod_q == 3'd0)                          t_w = sub_out ^ {rcon_q, 24'h0};
      else if (nk_q == 4'd8 && imod_q == 3'd4)     t_w = sub_out;
   end
   assign new_w = back_w ^ t_w;

   always_comb begin
      state_d  = state_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      kv_d     = kv_q;
      nr_d     = nr_q;
      run_nr_d = run_nr_q;
      nk_d     = nk_q;
      imod_d   = imod_q;
      i_d      = i_q;
      last_d   = last_q;
      rcon_d   = rcon_q;
      accept   = 1'b0;
      wr_word  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus_if.start) begin
               if (bus_if.key_len == KL_ILLEGAL) begin
                  err_d = 1'b1;
               end else begin
                  accept   = 1'b1;
                  state_d  = ST_EXPAND;
                  ready_d  = 1'b0;
                  busy_d   = 1'b1;
                  kv_d     = 1'b0;
                  nk_d     = nk_of(bus_if.key_len);
                  run_nr_d = nr_of(bus_if.key_len);
                  last_d   = last_of(bus_if.key_len);
                  i_d      = WIDX_W'(nk_of(bus_if.key_len));
                  imod_d   = 3'd0;
                  rcon_d   = RCON_INIT;
               end
            end
         end
         ST_EXPAND: begin
            wr_word = 1'b1;
            i_d     = i_q + 6'd1;
            imod_d  = (imod_q == 3'(nk_q - 4'd1)) ? 3'd0 : imod_q + 3'd1;
            if (imod_q == 3'd0) rcon_d = xtime(rcon_q);
            if (i_q == last_q) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               kv_d    = 1'b1;
               nr_d    = run_nr_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Read port drops the old schedule as soon as a new request is accepted
      rk_sel  = (bus_if.rk_idx <= nr_q) ? bus_if.rk_idx : '0;
      rk_base = {rk_sel, 2'b00};
      rk_d    = '0;
      if (kv_q && !accept && bus_if.rk_idx <= nr_q)
         rk_d = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         kv_q     <= 1'b0;
         nr_q     <= '0;
         run_nr_q <= '0;
         nk_q     <= 4'd4;
         imod_q   <= '0;
         i_q      <= '0;
         last_q   <= '0;
         rcon_q   <= RCON_INIT;
         rk_q     <= '0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         kv_q     <= kv_d;
         nr_q     <= nr_d;
         run_nr_q <= run_nr_d;
         nk_q     <= nk_d;
         imod_q   <= imod_d;
         i_q      <= i_d;
         last_q   <= last_d;
         rcon_q   <= rcon_d;
         rk_q     <= rk_d;
      end
   end

   // Schedule storage; contents are qualified by key_valid so no reset is needed
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < 8; k++)
            if (4'(k) < nk_d) w_q[6'(k)] <= bus_if.key[KEY_W-1-32*k -: 32];
      end else if (wr_word) begin
         w_q[i_q] <= new_w;
      end
   end

   assign bus_if.ready     = ready_q;
   assign bus_if.busy      = busy_q;
   assign bus_if.done      = done_q;
   assign bus_if.err       = err_q;
   assign bus_if.key_valid = kv_q;
   assign bus_if.nr        = nr_q;
   assign bus_if.rk_out    = rk_q;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed-vector bench for key_schedule_iter using FIPS-197 key expansion vectors.
module tb_key_schedule_iter;
   import key_schedule_iter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   key_schedule_iter_if bus ();

   key_schedule_iter dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Unused low bits of the shorter keys carry junk that must be ignored
   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_55aa55aa};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffff0000_12345678};
   localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RK192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
   localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] RK256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_rk(input logic [3:0] idx, output logic [127:0] v);
      bus.rk_idx = idx;
      tick();
      v = bus.rk_out;
   endtask

   // Issue a request and wait for done; lat counts cycles from the accept cycle to the done cycle
   task automatic run_key(input logic [1:0] kl, input logic [255:0] k, input bit hold,
                          input logic [3:0] prev_nr, input string name, output int lat);
      bus.start = 1'b1; bus.key_len = kl; bus.key = k;
      tick();
      if (!hold) bus.start = 1'b0;
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_accept: got %b want 1", name, bus.busy); end
      n_checks++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL %s ready_after_accept: got %b want 0", name, bus.ready); end
      lat = 1;
      while (bus.done !== 1'b1 && lat < 200) begin
         if (hold && lat == 20) begin
            n_checks++; if (bus.rk_out !== 128'h0) begin n_fail++; $display("FAIL %s rk_mid_run: got %h want 0", name, bus.rk_out); end
            n_checks++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL %s kv_mid_run: got %b want 0", name, bus.key_valid); end
            n_checks++; if (bus.nr !== prev_nr) begin n_fail++; $display("FAIL %s nr_mid_run: got %0d want %0d", name, bus.nr, prev_nr); end
            bus.key = '1;
         end
         tick();
         lat++;
      end
      bus.start = 1'b0;
      if (lat >= 200) $display("FAIL %s timeout: no done after %0d cycles", name, lat);
   endtask

   task automatic post_done(input string name, input int lat, input int exp_lat, input logic [3:0] exp_nr);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
      n_checks++; if (bus.key_valid !== 1'b1) begin n_fail++; $display("FAIL %s key_valid: got %b want 1", name, bus.key_valid); end
      n_checks++; if (bus.nr !== exp_nr) begin n_fail++; $display("FAIL %s nr: got %0d want %0d", name, bus.nr, exp_nr); end
      n_checks++; if ({bus.ready, bus.busy} !== 2'b10) begin n_fail++; $display("FAIL %s ready_busy: got %b want 10", name, {bus.ready, bus.busy}); end
      tick();
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse: got %b want 0", name, bus.done); end
   endtask

   task automatic test_reset();
      logic [6:0] got;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      got = {bus.ready, bus.busy, bus.done, bus.err, bus.key_valid, bus.rk_out == 128'h0, bus.nr == 4'd0};
      n_checks++; if (got !== 7'b1000011) begin n_fail++; $display("FAIL reset_state: got %b want 1000011", got); end
   endtask

   task automatic test_aes128();
      int lat; logic [127:0] v;
      run_key(KL_128, KEY128, 1'b0, 4'd0, "aes128", lat);
      post_done("aes128", lat, 41, 4'd10);
      read_rk(4'd10, v);
      n_checks++; if (v !== RK128_10) begin n_fail++; $display("FAIL aes128_rk10: got %h want %h", v, RK128_10); end
      read_rk(4'd0, v);
      n_checks++; if (v !== RK128_0) begin n_fail++; $display("FAIL aes128_rk0: got %h want %h", v, RK128_0); end
      read_rk(4'd1, v);
      n_checks++; if (v !== RK128_1) begin n_fail++; $display("FAIL aes128_rk1: got %h want %h", v, RK128_1); end
   endtask

   task automatic test_illegal();
      logic [127:0] v;
      read_rk(4'd10, v);
      bus.start = 1'b1; bus.key_len = KL_ILLEGAL; bus.key = KEY256;
      tick();
      bus.start = 1'b0;
      n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b want 1", bus.err); end
      n_checks++; if ({bus.ready, bus.busy, bus.key_valid} !== 3'b101) begin n_fail++; $display("FAIL illegal_status: got %b want 101", {bus.ready, bus.busy, bus.key_valid}); end
      n_checks++; if (bus.nr !== 4'd10) begin n_fail++; $display("FAIL illegal_nr: got %0d want 10", bus.nr); end
      n_checks++; if (bus.rk_out !== RK128_10) begin n_fail++; $display("FAIL illegal_rk: got %h want %h", bus.rk_out, RK128_10); end
      tick();
      n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse: got %b want 0", bus.err); end
      n_checks++; if (bus.rk_out !== RK128_10) begin n_fail++; $display("FAIL illegal_rk_after: got %h want %h", bus.rk_out, RK128_10); end
   endtask

   task automatic test_aes192();
      int lat; logic [127:0] v;
      run_key(KL_192, KEY192, 1'b0, 4'd10, "aes192", lat);
      post_done("aes192", lat, 47, 4'd12);
      read_rk(4'd12, v);
      n_checks++; if (v !== RK192_12) begin n_fail++; $display("FAIL aes192_rk12: got %h want %h", v, RK192_12); end
      read_rk(4'd0, v);
      n_checks++; if (v !== RK192_0) begin n_fail++; $display("FAIL aes192_rk0: got %h want %h", v, RK192_0); end
      read_rk(4'd13, v);
      n_checks++; if (v !== 128'h0) begin n_fail++; $display("FAIL aes192_rk13_oob: got %h want 0", v); end
   endtask

   task automatic test_aes256();
      int lat; logic [127:0] v;
      run_key(KL_256, KEY256, 1'b0, 4'd12, "aes256", lat);
      post_done("aes256", lat, 53, 4'd14);
      read_rk(4'd14, v);
      n_checks++; if (v !== RK256_14) begin n_fail++; $display("FAIL aes256_rk14: got %h want %h", v, RK256_14); end
      read_rk(4'd1, v);
      n_checks++; if (v !== RK256_1) begin n_fail++; $display("FAIL aes256_rk1: got %h want %h", v, RK256_1); end
      read_rk(4'd15, v);
      n_checks++; if (v !== 128'h0) begin n_fail++; $display("FAIL aes256_rk15_oob: got %h want 0", v); end
   endtask

   task automatic test_start_held();
      int lat; logic [127:0] v;
      bus.rk_idx = 4'd0;
      run_key(KL_128, KEY128, 1'b1, 4'd14, "held", lat);
      post_done("held", lat, 41, 4'd10);
      read_rk(4'd11, v);
      n_checks++; if (v !== 128'h0) begin n_fail++; $display("FAIL held_rk11_oob: got %h want 0", v); end
      read_rk(4'd10, v);
      n_checks++; if (v !== RK128_10) begin n_fail++; $display("FAIL held_rk10: got %h want %h", v, RK128_10); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [6:0] got; logic [127:0] v;
      bus.rk_idx = 4'd10;
      bus.start = 1'b1; bus.key_len = KL_256; bus.key = KEY256;
      tick();
      bus.start = 1'b0;
      repeat (19) tick();
      rst_n = 1'b0;
      #2;
      got = {bus.ready, bus.busy, bus.done, bus.err, bus.key_valid, bus.rk_out == 128'h0, bus.nr == 4'd0};
      n_checks++; if (got !== 7'b1000011) begin n_fail++; $display("FAIL midreset_state: got %b want 1000011", got); end
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_kv_after: got %b want 0", bus.key_valid); end
      run_key(KL_128, KEY128, 1'b0, 4'd0, "after_reset", lat);
      post_done("after_reset", lat, 41, 4'd10);
      read_rk(4'd10, v);
      n_checks++; if (v !== RK128_10) begin n_fail++; $display("FAIL after_reset_rk10: got %h want %h", v, RK128_10); end
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.key_len = 2'd0;
      bus.key     = '0;
      bus.rk_idx  = '0;
      test_reset();
      test_aes128();
      test_illegal();
      test_aes192();
      test_aes256();
      test_start_held();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
